hls_call_driver: RTL

//  Initiator side of the HLS component call/return interface (call.valid/.stall, return.valid/.stall, idx/returndata).

---
 rtl/hls_call_driver.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hls_call_driver.sv
// hls_call_driver: issues a run of indexed calls to one pipelined HLS component and
// collects its returns, in order, into a first-word-fall-through result FIFO and a running sum.
module hls_call_driver #(
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 16,
  parameter int ACC_W        = 48,
  parameter int FIFO_DEPTH   = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cmd_go,
  input  logic [DATA_W-1:0] cmd_base,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic              run_busy,
  output logic              run_done,
  output logic [ACC_W-1:0]  run_sum,
  output logic              run_err,
  output logic              call_start,
  input  logic              call_busy,
  output logic [DATA_W-1:0] call_idx,
  input  logic              ret_done,
  output logic              ret_stall,
  input  logic [DATA_W-1:0] ret_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data
);

  // state | meaning
  // IDLE  | waiting for cmd_go
  // ISSUE | issuing calls while credit allows, collecting returns
  // DRAIN | all calls issued, waiting for the remaining returns
  // DONE  | one-cycle run_done pulse
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  base_r;
  logic [CNT_W-1:0]   count_r, issued, returned;
  logic [CNT_W-1:0]   issued_inc, returned_inc;
  logic [INF_W-1:0]   inflight;
  logic [ACC_W-1:0]   sum_r;
  logic               err_r;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OCC_W-1:0]   fifo_cnt;
  logic [31:0]        occupancy;
  logic               fifo_full, credit_ok, go_ok;
  logic               call_acc, ret_acc, ret_stray, ret_good, push, pop;
  logic               last_call, last_ret;

  assign fifo_full  = (32'(fifo_cnt) == 32'(FIFO_DEPTH));
  assign occupancy  = 32'(inflight) + 32'(fifo_cnt);
  // Credit covers both in-flight calls and results already parked in the FIFO,
  // so every outstanding return is guaranteed a FIFO slot.
  assign credit_ok  = (32'(inflight) < 32'(MAX_INFLIGHT)) && (occupancy < 32'(FIFO_DEPTH));

  assign call_start = (state == ISSUE) && credit_ok;
  assign call_idx   = base_r + DATA_W'(issued);
  assign ret_stall  = fifo_full;

  assign call_acc   = call_start && !call_busy;
  assign ret_acc    = ret_done && !ret_stall;
  // A return alongside an accepted call is a zero-latency return, not a stray one.
  assign ret_stray  = ret_acc && (inflight == '0) && !call_acc;
  assign ret_good   = ret_acc && !ret_stray;
  assign push       = ret_good;
  assign res_valid  = (fifo_cnt != '0);
  assign pop        = res_valid && res_ready;
  assign res_data   = res_valid ? mem[rd_ptr] : '0;

  assign issued_inc   = issued + CNT_W'(1);
  assign returned_inc = returned + CNT_W'(1);
  assign last_call    = call_acc && (issued_inc == count_r);
  assign last_ret     = ret_good && (returned_inc == count_r);
  assign go_ok        = (state == IDLE) && cmd_go;

  assign run_busy = (state == ISSUE) || (state == DRAIN);
  assign run_done = (state == DONE);
  assign run_sum  = sum_r;
  assign run_err  = err_r;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_go) state_nxt = (cmd_count == '0) ? DONE : ISSUE;
      ISSUE:   if (last_call) state_nxt = last_ret ? DONE : DRAIN;
      DRAIN:   if (last_ret) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      base_r   <= '0;
      count_r  <= '0;
      issued   <= '0;
      returned <= '0;
      inflight <= '0;
      sum_r    <= '0;
      err_r    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (go_ok) begin
        base_r   <= cmd_base;
        count_r  <= cmd_count;
        issued   <= '0;
        returned <= '0;
        sum_r    <= '0;
      end else begin
        if (call_acc) issued <= issued_inc;
        if (ret_good) begin
          returned <= returned_inc;
          sum_r    <= sum_r + ACC_W'(ret_data);
        end
      end
      if (call_acc && !ret_good)      inflight <= inflight + INF_W'(1);
      else if (ret_good && !call_acc) inflight <= inflight - INF_W'(1);
      if (ret_stray) err_r <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + OCC_W'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - OCC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= ret_data;
  end

endmodule
